// File: rtl/req_onehot_arbiter_pkg.sv
// Shared types, sizes and helpers for the request one-hot arbiter.
// The downstream 8-to-3 encoder fixes the line count at 8.
package req_onehot_arbiter_pkg;

    localparam int unsigned ARB_N           = 8;
    localparam int unsigned ARB_SYNC_STAGES = 2;
    localparam int unsigned ARB_IDX_W       = $clog2(ARB_N);

    typedef logic [ARB_N-1:0]     arb_vec_t;
    typedef logic [ARB_IDX_W-1:0] arb_idx_t;

    // First set bit of vec scanning ptr, ptr+1, .. wrapping; ARB_N is a power of two.
    function automatic arb_idx_t rr_pick(input arb_vec_t vec, input arb_idx_t ptr);
        arb_idx_t idx;
        logic     found;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < ARB_N; k++) begin
            idx = ptr + ARB_IDX_W'(k);
            if (!found && vec[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic arb_vec_t onehot(input arb_idx_t idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/req_onehot_arbiter_if.sv
// Grant handshake between the arbiter (master) and the encoder stage (slave).
interface req_onehot_arbiter_if
    import req_onehot_arbiter_pkg::*;
#(
    parameter int unsigned N = ARB_N
);
    logic [N-1:0] grant;
    logic         grant_valid;
    logic         grant_ready;

    modport master (output grant, output grant_valid, input grant_ready);
    modport slave  (input grant, input grant_valid, output grant_ready);
endinterface

// File: rtl/req_edge_sync.sv
// Per-line synchroniser plus rising-edge detector for one asynchronous request line.
module req_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;
    logic [SYNC_STAGES:0]   arm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_q    <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s_q    <= sync_q[SYNC_STAGES-1];
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Detector stays disarmed until s_q holds a real post-reset sample, so a line
    // already high at reset release is not mistaken for an edge.
    always_comb begin
        rise = sync_q[SYNC_STAGES-1] & ~s_q & arm_q[SYNC_STAGES];
    end

endmodule

// File: rtl/req_onehot_arbiter.sv
// Sticky pending capture of request edges and round-robin selection into a
// registered one-hot grant with valid/ready handshake.
module req_onehot_arbiter
    import req_onehot_arbiter_pkg::*;
#(
    parameter int unsigned N           = ARB_N,
    parameter int unsigned SYNC_STAGES = ARB_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_in,
    input  logic                 clr_ovf,
    req_onehot_arbiter_if.master gnt,
    output logic [N-1:0]         pending,
    output logic [N-1:0]         overflow
);

    logic [N-1:0] rise;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] overflow_q, overflow_d;
    logic [N-1:0] grant_q, grant_d;
    logic         valid_q, valid_d;
    arb_idx_t     ptr_q, ptr_d;
    arb_idx_t     winner;
    logic [N-1:0] clr_vec, cand;
    logic         acc, update;

    for (genvar i = 0; i < N; i++) begin : g_sync
        req_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (req_in[i]),
            .rise (rise[i])
        );
    end

    always_comb begin
        acc        = valid_q & gnt.grant_ready;
        clr_vec    = acc ? grant_q : '0;
        // A new edge on a line being accepted re-arms it rather than counting as lost.
        pending_d  = rise | (pending_q & ~clr_vec);
        overflow_d = (clr_ovf ? '0 : overflow_q) | (rise & pending_q & ~clr_vec);
        cand       = pending_q & ~clr_vec;
        update     = ~valid_q | acc;
        winner     = rr_pick(cand, ptr_q);

        grant_d = grant_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (update) begin
            if (cand != '0) begin
                grant_d = onehot(winner);
                valid_d = 1'b1;
                ptr_d   = winner + ARB_IDX_W'(1);
            end else begin
                grant_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            ptr_q      <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt.grant       = grant_q;
    assign gnt.grant_valid = valid_q;
    assign pending         = pending_q;
    assign overflow        = overflow_q;

endmodule
